sad_min_search: RTL and testbench
=================================

# sad_min_search

Downstream consumer of the SAD engine's result memory (C memory: 128 × 32-bit SAD values, 7-bit address). On `Go`, it scans every entry and reports the minimum SAD value and the index of that entry, which is the best-match candidate. It shares the single-port read timing of the input memories. It runs only after the SAD engine has asserted `Done`, and is sequenced by the same controller.

## Interface
- `N_ENTRIES`, 128: number of C-memory entries scanned, from index 0 to `N_ENTRIES`-1.
- `ADDR_W`, 7: C-memory address width.
- `DATA_W`, 32: SAD value width.

- `Clk`, in, 1: the single clock; all state changes on its rising edge.
- `Rst`, in, 1: reset, asynchronous, active-high.
- `Go`, in, 1: start request; sampled only in IDLE.
- `C_Data`, in, `DATA_W`: read data from C memory.
- `C_Addr`, out, `ADDR_W`: C-memory address. Registered.
- `C_RW`, out, 1: always 0 (read only). Registered.
- `C_En`, out, 1: C-memory enable. Registered.
- `Busy`, out, 1: high in every state except IDLE.
- `Done`, out, 1: one-cycle pulse when the result is valid.
- `Min_Out`, out, `DATA_W`: minimum SAD. Holds its value until the next scan's FIN.
- `Min_Idx`, out, `ADDR_W`: index of the minimum. Holds its value until the next scan's FIN.

## Operation
- States and transitions:
  - IDLE: go to INIT if `Go`=1, else stay.
  - INIT: `Min` ← all ones, `Idx` ← 0, `K` ← 0; go to ISSUE.
  - ISSUE: `C_Addr` ← `K`, `C_En` ← 1; go to WAIT.
  - WAIT: go to CMP.
  - CMP: sample `C_Data`. If `C_Data` < `Min` (unsigned, strict), then `Min` ← `C_Data` and `Idx` ← `K`. If `K` = `N_ENTRIES`-1, go to FIN; else `K` ← `K`+1 and go to ISSUE.
  - FIN: `Min_Out` ← `Min`, `Min_Idx` ← `Idx`, `Done` ← 1; go to IDLE.
- `C_Addr`, `C_En` and `C_RW` default to 0 in every cycle except the one following ISSUE.
- Ties keep the lowest index, because the compare is strict less-than.
- An entry equal to 0xFFFF_FFFF still produces a valid result. If all entries are 0xFFFF_FFFF, `Min_Idx` = 0.
- `K` is `ADDR_W`+1 bits wide, so it never wraps before the terminal compare.
- `Go` outside IDLE is ignored; there is no queuing.
- If `Go` is held high through FIN, a new scan starts on the first IDLE cycle.
- Reset: all outputs go to 0 and the state goes to IDLE, asynchronously. Asserting reset mid-scan aborts the scan with no `Done` pulse and clears `Min_Out`/`Min_Idx`.

## Timing
- Memory read latency is 2 cycles: address and enable are registered on the ISSUE edge, and data is sampled on the CMP edge two edges later.
- Each entry takes 3 cycles (ISSUE, WAIT, CMP).
- If `Go` is sampled at edge e0, then INIT is at e1 and the last CMP is at e0+3·`N_ENTRIES`+1.
- `Done` goes high at e0+3·`N_ENTRIES`+2, which is e0+386 for N=128, and stays high for exactly one cycle.
- `Min_Out`/`Min_Idx` update on the same edge as `Done` and are stable from then on.
- `Busy` goes high at e0+1 and low on the edge where `Done` goes low.

## Structure
- A shared package holds:
  - the state encoding: IDLE, INIT, ISSUE, WAIT, CMP, FIN as 3-bit constants;
  - the C-memory geometry constants: 128 entries, 7-bit address, 32-bit data, which are also used by the SAD engine.
- No sub-module is needed; a single FSM plus a datapath in one always block is sufficient.

## Test plan
- Memory entries 0..127 hold 1000-i (that is, 1000 down to 873); `Go` pulse → `Done` at e0+386, `Min_Out`=873, `Min_Idx`=127.
- All entries are 500 except entry 40 = 12 and entry 90 = 12 → `Min_Out`=12, `Min_Idx`=40 (tie keeps the lower index).
- All entries are 0xFFFF_FFFF → `Min_Out`=0xFFFF_FFFF, `Min_Idx`=0.
- Address trace check → 128 `C_En` pulses, each one cycle wide, at addresses 0..127 in order and 3 cycles apart, with `C_RW`=0 throughout.
- `Go` pulsed again at e0+100 during a scan → ignored; exactly one `Done` at e0+386.
- `Rst` asserted at e0+200 → outputs go to 0 immediately; no `Done` pulse. A later `Go` runs a full, correct scan.

Source files
------------

// File: rtl/sad_min_search_pkg.sv
// Shared state encoding and C-memory geometry for the SAD engine and the
// minimum-search block that consumes its result memory.
package sad_min_search_pkg;

  localparam int N_ENTRIES = 128;
  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 32;
  localparam int K_W       = ADDR_W + 1;

  localparam logic [K_W-1:0] K_LAST = K_W'(N_ENTRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_CMP   = 3'd4,
    S_FIN   = 3'd5
  } state_t;

endpackage

// File: rtl/sad_min_search_if.sv
// Control, C-memory read port and result signals of the minimum search.
interface sad_min_search_if;
  import sad_min_search_pkg::*;

  logic              Go;
  logic [DATA_W-1:0] C_Data;
  logic [ADDR_W-1:0] C_Addr;
  logic              C_RW;
  logic              C_En;
  logic              Busy;
  logic              Done;
  logic [DATA_W-1:0] Min_Out;
  logic [ADDR_W-1:0] Min_Idx;

  modport master (
    output Go, C_Data,
    input  C_Addr, C_RW, C_En, Busy, Done, Min_Out, Min_Idx
  );

  modport slave (
    input  Go, C_Data,
    output C_Addr, C_RW, C_En, Busy, Done, Min_Out, Min_Idx
  );

endinterface

// File: rtl/sad_min_search.sv
// Scans all C-memory entries and reports the smallest SAD and its index.
// One entry per ISSUE/WAIT/CMP triple, matching the 2-cycle memory read.
module sad_min_search
  import sad_min_search_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  sad_min_search_if.slave  bus
);

  state_t            state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] c_addr_q, c_addr_d;
  logic              c_en_q, c_en_d;
  logic              c_rw_q, c_rw_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] min_out_q, min_out_d;
  logic [ADDR_W-1:0] min_idx_q, min_idx_d;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    min_d     = min_q;
    idx_d     = idx_q;
    c_addr_d  = '0;
    c_en_d    = 1'b0;
    c_rw_d    = 1'b0;
    busy_d    = (state_q != S_IDLE);
    done_d    = 1'b0;
    min_out_d = min_out_q;
    min_idx_d = min_idx_q;

    case (state_q)
      S_IDLE: if (bus.Go) state_d = S_INIT;
      S_INIT: begin
        min_d   = '1;
        idx_d   = '0;
        k_d     = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        c_addr_d = k_q[ADDR_W-1:0];
        c_en_d   = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: state_d = S_CMP;
      S_CMP: begin
        // strict compare so ties keep the earliest index
        if (bus.C_Data < min_q) begin
          min_d = bus.C_Data;
          idx_d = k_q[ADDR_W-1:0];
        end
        if (k_q == K_LAST) begin
          state_d = S_FIN;
        end else begin
          k_d     = k_q + K_W'(1);
          state_d = S_ISSUE;
        end
      end
      S_FIN: begin
        min_out_d = min_q;
        min_idx_d = idx_q;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      min_q     <= '0;
      idx_q     <= '0;
      c_addr_q  <= '0;
      c_en_q    <= 1'b0;
      c_rw_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      min_out_q <= '0;
      min_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      min_q     <= min_d;
      idx_q     <= idx_d;
      c_addr_q  <= c_addr_d;
      c_en_q    <= c_en_d;
      c_rw_q    <= c_rw_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      min_out_q <= min_out_d;
      min_idx_q <= min_idx_d;
    end
  end

  assign bus.C_Addr  = c_addr_q;
  assign bus.C_En    = c_en_q;
  assign bus.C_RW    = c_rw_q;
  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.Min_Out = min_out_q;
  assign bus.Min_Idx = min_idx_q;

endmodule

// File: tb/tb_sad_min_search.sv
// Directed bench for sad_min_search with a 2-cycle-latency C-memory model.
module tb_sad_min_search;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sad_min_search_if bus_if ();

  sad_min_search dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus_if)
  );

  logic [31:0] mem [128];

  // address registered by the DUT at ISSUE, data registered here one edge later
  always @(posedge clk)
    if (bus_if.C_En) bus_if.C_Data <= mem[bus_if.C_Addr];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_at;
  int          done_cnt;
  int          rw_bad;
  int          en_n[$];
  logic [6:0]  en_a[$];
  logic        busy_1, busy_386, busy_387;
  logic [31:0] min_before;

  task automatic run_scan(input int go_again_at);
    done_at  = -1;
    done_cnt = 0;
    rw_bad   = 0;
    en_n.delete();
    en_a.delete();
    @(negedge clk);
    bus_if.Go = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.Go = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (bus_if.Done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (bus_if.C_En) begin
        en_n.push_back(n);
        en_a.push_back(bus_if.C_Addr);
      end
      if (bus_if.C_RW !== 1'b0) rw_bad++;
      if (n == 1)   busy_1   = bus_if.Busy;
      if (n == 385) min_before = bus_if.Min_Out;
      if (n == 386) busy_386 = bus_if.Busy;
      if (n == 387) busy_387 = bus_if.Busy;
      if (n == go_again_at - 1) bus_if.Go = 1'b1;
      if (n == go_again_at)     bus_if.Go = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus_if.Go = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus_if.C_Addr !== 7'd0) begin n_fail++; $display("FAIL reset_c_addr got %0d want 0", bus_if.C_Addr); end
    n_checks++; if (bus_if.C_En !== 1'b0) begin n_fail++; $display("FAIL reset_c_en got %b want 0", bus_if.C_En); end
    n_checks++; if (bus_if.C_RW !== 1'b0) begin n_fail++; $display("FAIL reset_c_rw got %b want 0", bus_if.C_RW); end
    n_checks++; if (bus_if.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus_if.Busy); end
    n_checks++; if (bus_if.Done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus_if.Done); end
    n_checks++; if (bus_if.Min_Out !== 32'd0) begin n_fail++; $display("FAIL reset_min_out got %0h want 0", bus_if.Min_Out); end
    n_checks++; if (bus_if.Min_Idx !== 7'd0) begin n_fail++; $display("FAIL reset_min_idx got %0d want 0", bus_if.Min_Idx); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_descending;
    for (int i = 0; i < 128; i++) mem[i] = 32'(1000 - i);
    run_scan(0);
    n_checks++; if (done_at !== 386) begin n_fail++; $display("FAIL desc_done_at got %0d want 386", done_at); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL desc_done_cnt got %0d want 1", done_cnt); end
    n_checks++; if (bus_if.Min_Out !== 32'd873) begin n_fail++; $display("FAIL desc_min_out got %0d want 873", bus_if.Min_Out); end
    n_checks++; if (bus_if.Min_Idx !== 7'd127) begin n_fail++; $display("FAIL desc_min_idx got %0d want 127", bus_if.Min_Idx); end
    n_checks++; if (busy_1 !== 1'b1) begin n_fail++; $display("FAIL desc_busy_e1 got %b want 1", busy_1); end
    n_checks++; if (busy_386 !== 1'b1) begin n_fail++; $display("FAIL desc_busy_e386 got %b want 1", busy_386); end
    n_checks++; if (busy_387 !== 1'b0) begin n_fail++; $display("FAIL desc_busy_e387 got %b want 0", busy_387); end
    n_checks++; if (min_before !== 32'd0) begin n_fail++; $display("FAIL desc_min_hold got %0d want 0", min_before); end
  endtask

  task automatic test_tie;
    for (int i = 0; i < 128; i++) mem[i] = 32'd500;
    mem[40] = 32'd12;
    mem[90] = 32'd12;
    run_scan(0);
    n_checks++; if (done_at !== 386) begin n_fail++; $display("FAIL tie_done_at got %0d want 386", done_at); end
    n_checks++; if (bus_if.Min_Out !== 32'd12) begin n_fail++; $display("FAIL tie_min_out got %0d want 12", bus_if.Min_Out); end
    n_checks++; if (bus_if.Min_Idx !== 7'd40) begin n_fail++; $display("FAIL tie_min_idx got %0d want 40", bus_if.Min_Idx); end
    n_checks++; if (min_before !== 32'd873) begin n_fail++; $display("FAIL tie_min_hold got %0d want 873", min_before); end
  endtask

  task automatic test_all_ones;
    for (int i = 0; i < 128; i++) mem[i] = 32'hFFFF_FFFF;
    run_scan(0);
    n_checks++; if (done_at !== 386) begin n_fail++; $display("FAIL ones_done_at got %0d want 386", done_at); end
    n_checks++; if (bus_if.Min_Out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL ones_min_out got %0h want ffffffff", bus_if.Min_Out); end
    n_checks++; if (bus_if.Min_Idx !== 7'd0) begin n_fail++; $display("FAIL ones_min_idx got %0d want 0", bus_if.Min_Idx); end
  endtask

  task automatic test_trace;
    for (int i = 0; i < 128; i++) mem[i] = 32'(2 * i + 7);
    run_scan(0);
    n_checks++; if (en_n.size() !== 128) begin n_fail++; $display("FAIL trace_en_count got %0d want 128", en_n.size()); end
    n_checks++; if (rw_bad !== 0) begin n_fail++; $display("FAIL trace_c_rw got %0d high cycles want 0", rw_bad); end
    for (int k = 0; k < 128 && k < en_n.size(); k++) begin
      n_checks++;
      if (en_n[k] !== 2 + 3 * k || en_a[k] !== 7'(k)) begin
        n_fail++;
        $display("FAIL trace_pulse_%0d got cycle %0d addr %0d want cycle %0d addr %0d",
                 k, en_n[k], en_a[k], 2 + 3 * k, k);
      end
    end
    n_checks++; if (bus_if.Min_Out !== 32'd7) begin n_fail++; $display("FAIL trace_min_out got %0d want 7", bus_if.Min_Out); end
  endtask

  task automatic test_go_during_scan;
    for (int i = 0; i < 128; i++) mem[i] = 32'(300 + (i % 10));
    mem[64] = 32'd299;
    run_scan(100);
    n_checks++; if (done_at !== 386) begin n_fail++; $display("FAIL go2_done_at got %0d want 386", done_at); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL go2_done_cnt got %0d want 1", done_cnt); end
    n_checks++; if (bus_if.Min_Idx !== 7'd64) begin n_fail++; $display("FAIL go2_min_idx got %0d want 64", bus_if.Min_Idx); end
    n_checks++; if (bus_if.Busy !== 1'b0) begin n_fail++; $display("FAIL go2_busy_end got %b want 0", bus_if.Busy); end
  endtask

  task automatic test_reset_mid_scan;
    int dones;
    for (int i = 0; i < 128; i++) mem[i] = 32'd700;
    mem[5]   = 32'd4;
    mem[127] = 32'd3;
    @(negedge clk);
    bus_if.Go = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.Go = 1'b0;
    repeat (200) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (bus_if.Min_Out !== 32'd0) begin n_fail++; $display("FAIL rstmid_min_out got %0d want 0", bus_if.Min_Out); end
    n_checks++; if (bus_if.Min_Idx !== 7'd0) begin n_fail++; $display("FAIL rstmid_min_idx got %0d want 0", bus_if.Min_Idx); end
    n_checks++; if (bus_if.Busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", bus_if.Busy); end
    n_checks++; if (bus_if.C_En !== 1'b0) begin n_fail++; $display("FAIL rstmid_c_en got %b want 0", bus_if.C_En); end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      if (bus_if.Done) dones++;
    end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL rstmid_no_done got %0d want 0", dones); end
    run_scan(0);
    n_checks++; if (done_at !== 386) begin n_fail++; $display("FAIL rstmid_rescan_done_at got %0d want 386", done_at); end
    n_checks++; if (bus_if.Min_Out !== 32'd3) begin n_fail++; $display("FAIL rstmid_rescan_min_out got %0d want 3", bus_if.Min_Out); end
    n_checks++; if (bus_if.Min_Idx !== 7'd127) begin n_fail++; $display("FAIL rstmid_rescan_min_idx got %0d want 127", bus_if.Min_Idx); end
  endtask

  task automatic test_back_to_back;
    int pos[$];
    for (int i = 0; i < 128; i++) mem[i] = 32'(1000 - i);
    @(negedge clk);
    bus_if.Go = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 780; n++) begin
      @(posedge clk);
      #1;
      if (bus_if.Done) pos.push_back(n);
      if (n == 388) bus_if.Go = 1'b0;
    end
    n_checks++; if (pos.size() !== 2) begin n_fail++; $display("FAIL b2b_done_cnt got %0d want 2", pos.size()); end
    n_checks++; if (pos.size() > 0 && pos[0] !== 386) begin n_fail++; $display("FAIL b2b_first_done got %0d want 386", pos[0]); end
    n_checks++; if (pos.size() > 1 && pos[1] !== 773) begin n_fail++; $display("FAIL b2b_second_done got %0d want 773", pos[1]); end
    n_checks++; if (bus_if.Min_Idx !== 7'd127) begin n_fail++; $display("FAIL b2b_min_idx got %0d want 127", bus_if.Min_Idx); end
  endtask

  initial begin
    bus_if.Go = 1'b0;
    test_reset();
    test_descending();
    test_tie();
    test_all_ones();
    test_trace();
    test_go_during_scan();
    test_reset_mid_scan();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
